// File: rtl/nn_host_pkg.sv
// nn_host_pkg: address map, word constants and FSM state codes shared by the nn_host_seq files.
package nn_host_pkg;
  localparam int WIDTH      = 32;
  localparam int LENGHT_I   = 32;
  localparam int LENGHT_MID = 8;
  localparam int LENGHT_O   = 2;
  localparam int NW         = LENGHT_I*LENGHT_MID + LENGHT_MID*LENGHT_O;
  localparam int IB         = NW + 1;
  localparam int OB         = IB + LENGHT_I + 1;
  localparam int WIDTH_ADDR = $clog2(NW + LENGHT_I + LENGHT_O + 3);
  localparam int KW         = (LENGHT_O > 1) ? $clog2(LENGHT_O) : 1;
  typedef logic [WIDTH_ADDR-1:0] addr_t;
  typedef logic [WIDTH-1:0]      word_t;
  typedef logic [3:0]            state_t;
  localparam addr_t W_COMMIT    = addr_t'(NW);
  localparam addr_t I_COMMIT    = addr_t'(IB + LENGHT_I);
  localparam addr_t IB_A        = addr_t'(IB);
  localparam addr_t OB_A        = addr_t'(OB);
  localparam word_t COMMIT_WORD = '1;
  localparam state_t S_IDLE      = 4'd0;
  localparam state_t S_FETCH     = 4'd1;
  localparam state_t S_WRITE     = 4'd2;
  localparam state_t S_COMMIT    = 4'd3;
  localparam state_t S_GAP       = 4'd4;
  localparam state_t S_WAIT_DOWN = 4'd5;
  localparam state_t S_READ      = 4'd6;
  localparam state_t S_CAPTURE   = 4'd7;
  localparam state_t S_DONE      = 4'd8;
endpackage

// File: rtl/nn_host_seq_if.sv
// nn_host_seq_if: source-memory port and manager cpu-side bus of the host sequencer.
// master: host side (drives strobes/address/write data); slave: memory/manager side.
interface nn_host_seq_if;
  import nn_host_pkg::*;
  logic  src_rd;
  addr_t src_addr;
  word_t src_data;
  logic  mgr_write;
  logic  mgr_read;
  addr_t mgr_addr;
  word_t mgr_wdata;
  word_t mgr_rdata;
  logic  mgr_ready;
  logic  mgr_down;
  modport master (
    output src_rd, src_addr, mgr_write, mgr_read, mgr_addr, mgr_wdata,
    input  src_data, mgr_rdata, mgr_ready, mgr_down
  );
  modport slave (
    input  src_rd, src_addr, mgr_write, mgr_read, mgr_addr, mgr_wdata,
    output src_data, mgr_rdata, mgr_ready, mgr_down
  );
endinterface

// File: rtl/nn_host_wdog.sv
// nn_host_wdog: counts consecutive cycles with en high; expired on the LIMIT-th one.
// Ports: clk, reset (async active-low), en (waiting; low clears), expired (combinational).
module nn_host_wdog #(
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = en ? cnt_q + 1'b1 : '0;
  assign expired = en && (cnt_q == CW'(LIMIT - 1));
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/nn_host_seq.sv
// nn_host_seq: streams weights/inputs from source memory into the NN manager, commits, waits mgr_down, reads outputs.
module nn_host_seq
  import nn_host_pkg::*;
#(parameter int TMO_CYC = 4096)
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           skip_w,
  output logic                           busy,
  output logic                           done,
  output logic [LENGHT_O-1:0][WIDTH-1:0] res,
  output logic                           err,
  nn_host_seq_if.master                  bus
);
  state_t  state_q, state_d;
  logic    phase_q, phase_d;
  addr_t   ptr_q, ptr_d, ptr_inc, win_end;
  logic [KW-1:0] k_q, k_d;
  logic    gap_q, gap_d;
  logic    held_q, held_d;
  word_t   wdata_q, wdata_d;
  logic [LENGHT_O-1:0][WIDTH-1:0] res_q, res_d;
  logic    tmo, is_wr, is_rd;
  assign ptr_inc = ptr_q + 1'b1;
  assign win_end = phase_q ? I_COMMIT : W_COMMIT;
  assign is_wr   = (state_q == S_WRITE) || (state_q == S_COMMIT);
  assign is_rd   = state_q == S_FETCH;
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    ptr_d   = ptr_q;
    k_d     = k_q;
    gap_d   = gap_q;
    held_d  = held_q;
    wdata_d = wdata_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: if (start) begin
        phase_d = skip_w;
        ptr_d   = skip_w ? IB_A : '0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        held_d  = 1'b0;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        held_d = 1'b1;
        if (!held_q) wdata_d = bus.src_data;
        if (bus.mgr_ready) begin
          ptr_d   = ptr_inc;
          state_d = (ptr_inc == win_end) ? S_COMMIT : S_FETCH;
        end
      end
      S_COMMIT: if (bus.mgr_ready) begin
        gap_d   = 1'b0;
        state_d = S_GAP;
      end
      S_GAP: begin
        gap_d = 1'b1;
        if (gap_q) begin
          phase_d = 1'b1;
          ptr_d   = phase_q ? ptr_q : IB_A;
          state_d = phase_q ? S_WAIT_DOWN : S_FETCH;
        end
      end
      S_WAIT_DOWN: if (bus.mgr_down) begin
        k_d     = '0;
        state_d = S_READ;
      end
      S_READ: state_d = S_CAPTURE;
      S_CAPTURE: begin
        res_d[k_q] = bus.mgr_rdata;
        k_d        = (k_q == KW'(LENGHT_O - 1)) ? k_q : k_q + 1'b1;
        state_d    = (k_q == KW'(LENGHT_O - 1)) ? S_DONE : S_READ;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (tmo) state_d = S_IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= S_IDLE;
      phase_q <= 1'b0;
      ptr_q   <= '0;
      k_q     <= '0;
      gap_q   <= 1'b0;
      held_q  <= 1'b0;
      wdata_q <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      ptr_q   <= ptr_d;
      k_q     <= k_d;
      gap_q   <= gap_d;
      held_q  <= held_d;
      wdata_q <= wdata_d;
      res_q   <= res_d;
    end
  assign busy          = state_q != S_IDLE;
  assign done          = state_q == S_DONE;
  assign res           = res_q;
  assign bus.src_rd    = is_rd;
  assign bus.src_addr  = is_rd ? ptr_q : '0;
  assign bus.mgr_write = is_wr;
  assign bus.mgr_read  = state_q == S_READ;
  assign bus.mgr_addr  = is_wr ? ptr_q : (state_q == S_READ) ? OB_A + addr_t'(k_q) : '0;
  assign bus.mgr_wdata = (state_q == S_COMMIT) ? COMMIT_WORD :
                         (state_q == S_WRITE) ? (held_q ? wdata_q : bus.src_data) : '0;
`ifdef HOST_TIMEOUT_EN
  logic err_q, wd_en;
  assign wd_en = ((state_q == S_WAIT_DOWN) && !bus.mgr_down) || (is_wr && !bus.mgr_ready);
  nn_host_wdog #(.LIMIT(TMO_CYC)) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .en      (wd_en),
    .expired (tmo)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset)                            err_q <= 1'b0;
    else if (tmo)                          err_q <= 1'b1;
    else if ((state_q == S_IDLE) && start) err_q <= 1'b0;
  assign err = err_q;
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_nn_host_seq.sv
// tb_nn_host_seq: scoreboard bench for nn_host_seq with source/manager models.
module tb_nn_host_seq;
  import nn_host_pkg::*;
  logic clk = 0, reset = 0, start = 0, skip_w = 0;
  logic busy, done, err;
  logic [LENGHT_O-1:0][WIDTH-1:0] res;
  nn_host_seq_if bus();
  nn_host_seq #(.TMO_CYC(64)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .skip_w (skip_w),
    .busy   (busy),
    .done   (done),
    .res    (res),
    .err    (err),
    .bus    (bus.master)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [1:0]  kind;
    logic [8:0]  addr;
    logic [63:0] data;
  } ev_t;
  ev_t exp_q[$];
  int total = 0, passed = 0, done_cnt = 0, down_cnt = 0, stall_n = 0;
  bit down_en = 1, stall_on = 0;
  logic  down_r = 0, ready_r = 1;
  word_t src_r = '0, rdata_r = '0;
  assign bus.mgr_down  = down_r;
  assign bus.mgr_ready = ready_r;
  assign bus.src_data  = src_r;
  assign bus.mgr_rdata = rdata_r;
  function automatic void chk(string name, logic [63:0] act, logic [63:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got %h want %h", name, act, want);
  endfunction
  function automatic void see(ev_t a);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      $display("FAIL bus_seq: unexpected kind=%0d addr=%0d data=%h", a.kind, a.addr, a.data);
      return;
    end
    e = exp_q.pop_front();
    if (a === e) passed++;
    else $display("FAIL bus_seq: got kind=%0d addr=%0d data=%h want kind=%0d addr=%0d data=%h",
                  a.kind, a.addr, a.data, e.kind, e.addr, e.data);
  endfunction
  always @(posedge clk) if (bus.src_rd) src_r <= 32'(bus.src_addr) + 32'd1;
  always @(posedge clk) if (bus.mgr_read) rdata_r <= (bus.mgr_addr == 9'd306) ? 32'h11 : 32'h22;
  always @(posedge clk) begin
    if (bus.mgr_write && bus.mgr_ready && bus.mgr_addr == 9'd305) down_cnt <= 20;
    else if (down_cnt > 1) down_cnt <= down_cnt - 1;
    else if (down_cnt == 1) begin
      down_cnt <= 0;
      down_r   <= down_en;
    end
    if (done) down_r <= 1'b0;
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (stall_on && bus.mgr_write && bus.mgr_addr == 9'd100 && stall_n < 5) begin
      ready_r = 1'b0;
      stall_n++;
    end else ready_r = 1'b1;
  end
  initial begin
    bit    prev_stall;
    addr_t prev_addr;
    word_t prev_data;
    prev_stall = 0;
    prev_addr  = '0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (bus.mgr_write && bus.mgr_read) chk("wr_rd_excl", 64'd1, 64'd0);
        if (prev_stall)
          chk("stall_hold", {bus.mgr_write, bus.mgr_addr, bus.mgr_wdata}, {1'b1, prev_addr, prev_data});
        prev_stall = bus.mgr_write && !bus.mgr_ready;
        prev_addr  = bus.mgr_addr;
        prev_data  = bus.mgr_wdata;
        if (bus.mgr_write && bus.mgr_ready) see(ev_t'{2'd0, bus.mgr_addr, 64'(bus.mgr_wdata)});
        if (bus.mgr_read) see(ev_t'{2'd1, bus.mgr_addr, 64'd0});
        if (done) begin
          done_cnt++;
          see(ev_t'{2'd2, 9'd0, 64'(res)});
        end
      end else prev_stall = 0;
    end
  end
  task automatic push_run(bit skip, bit reads);
    if (!skip) begin
      for (int a = 0; a < 272; a++) exp_q.push_back(ev_t'{2'd0, 9'(a), 64'(a + 1)});
      exp_q.push_back(ev_t'{2'd0, 9'd272, 64'hFFFF_FFFF});
    end
    for (int a = 273; a < 305; a++) exp_q.push_back(ev_t'{2'd0, 9'(a), 64'(a + 1)});
    exp_q.push_back(ev_t'{2'd0, 9'd305, 64'hFFFF_FFFF});
    if (reads) begin
      exp_q.push_back(ev_t'{2'd1, 9'd306, 64'd0});
      exp_q.push_back(ev_t'{2'd1, 9'd307, 64'd0});
      exp_q.push_back(ev_t'{2'd2, 9'd0, 64'h0000_0022_0000_0011});
    end
  endtask
  task automatic pulse_start(bit skip);
    @(negedge clk);
    skip_w = skip;
    start  = 1;
    @(negedge clk);
    start  = 0;
    skip_w = 0;
    chk("start_busy_err", {busy, err}, 2'b10);
  endtask
  task automatic wait_done(string name);
    int d0, n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_seen"}, 64'(done_cnt - d0), 64'd1);
    @(negedge clk);
    chk({name, "_idle"}, {busy, done}, 2'b00);
    chk({name, "_queue_left"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_res"}, 64'(res), 64'h0000_0022_0000_0011);
  endtask
  task automatic check_idle(string name);
    chk({name, "_ctl"}, {busy, done, err, bus.src_rd, bus.mgr_write, bus.mgr_read}, 6'd0);
    chk({name, "_addr"}, {bus.src_addr, bus.mgr_addr}, 18'd0);
    chk({name, "_wdata"}, 64'(bus.mgr_wdata), 64'd0);
    chk({name, "_res"}, 64'(res), 64'd0);
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_idle("reset_state");
    reset = 1;
    push_run(0, 1);
    pulse_start(0);
    wait_done("full");
    stall_on = 1;
    push_run(0, 1);
    pulse_start(0);
    wait_done("stall");
    chk("stall_cycles", 64'(stall_n), 64'd5);
    stall_on = 0;
    push_run(1, 1);
    pulse_start(1);
    wait_done("skip_w");
    push_run(0, 1);
    pulse_start(0);
    n = 0;
    while (down_cnt != 15 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_wait_down", 64'(down_cnt), 64'd15);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done("ignored_start");
    push_run(0, 1);
    pulse_start(0);
    n = 0;
    while (!(bus.mgr_write && bus.mgr_addr == 9'd50) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_addr50", 64'(bus.mgr_addr), 64'd50);
    #2 reset = 0;
    #1 check_idle("async_reset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1;
    push_run(0, 1);
    pulse_start(0);
    wait_done("restart");
`ifdef HOST_TIMEOUT_EN
    down_en = 0;
    push_run(0, 0);
    pulse_start(0);
    n = 0;
    while (!(bus.mgr_write && bus.mgr_ready && bus.mgr_addr == 9'd305) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    begin
      int d0;
      d0 = done_cnt;
      n  = 0;
      while (!err && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("tmo_cycles", 64'(n), 64'd67);
      chk("tmo_state", {err, busy, done}, 3'b100);
      chk("tmo_no_done", 64'(done_cnt - d0), 64'd0);
      chk("tmo_queue_left", 64'(exp_q.size()), 64'd0);
    end
    down_en = 1;
    push_run(0, 1);
    pulse_start(0);
    wait_done("after_tmo");
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
